// File: rtl/recirculador_param.sv
// recirculador_param: routes LANES lanes to a registered forward or recirculate group under a debounced mode FSM.
// Optional define RECIRC_LANE_CHECK_EN adds the sticky lane_err misalignment flag.
module recirculador_param #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int HOLD   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    selector_IDLE,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic [LANES-1:0]        valid_in,
    input  logic                    cnt_clr,
    output logic [LANES*DATA_W-1:0] data_fwd,
    output logic [LANES-1:0]        valid_fwd,
    output logic [LANES*DATA_W-1:0] data_rec,
    output logic [LANES-1:0]        valid_rec,
    output logic                    mode,
    output logic [CNT_W-1:0]        fwd_count
`ifdef RECIRC_LANE_CHECK_EN
    ,
    output logic                    lane_err
`endif
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam int PW = $clog2(LANES + 1);

    logic [HW-1:0]           holdCnt;
    logic [LANES*DATA_W-1:0] masked;
    logic [PW-1:0]           pop;
    logic [CNT_W+PW-1:0]     sum;
    logic [CNT_W-1:0]        nextCount;

    // invalid lanes are zeroed so X never reaches either group
    always_comb begin
        masked = '0;
        pop    = '0;
        for (int i = 0; i < LANES; i++) begin
            masked[i*DATA_W +: DATA_W] = valid_in[i] ? data_in[i*DATA_W +: DATA_W] : '0;
            pop = pop + PW'(valid_in[i]);
        end
        sum       = {{PW{1'b0}}, fwd_count} + {{CNT_W{1'b0}}, pop};
        nextCount = sum > {{PW{1'b0}}, {CNT_W{1'b1}}} ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mode      <= 1'b0;
            holdCnt   <= '0;
            data_fwd  <= '0;
            valid_fwd <= '0;
            data_rec  <= '0;
            valid_rec <= '0;
            fwd_count <= '0;
        end else begin
            if (selector_IDLE != mode) begin
                if (holdCnt == HW'(HOLD - 1)) begin
                    mode    <= selector_IDLE;
                    holdCnt <= '0;
                end else begin
                    holdCnt <= holdCnt + 1'b1;
                end
            end else begin
                holdCnt <= '0;
            end
            data_fwd  <= mode ? masked : '0;
            valid_fwd <= mode ? valid_in : '0;
            data_rec  <= mode ? '0 : masked;
            valid_rec <= mode ? '0 : valid_in;
            fwd_count <= cnt_clr ? '0 : mode ? nextCount : fwd_count;
        end
    end

`ifdef RECIRC_LANE_CHECK_EN
    // a fresh misalignment outranks a same-edge clear
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) lane_err <= 1'b0;
        else          lane_err <= (valid_in != '0 && valid_in != '1) || (lane_err && !cnt_clr);
    end
`endif
endmodule

// File: tb/tb_recirculador_param.sv
// tb_recirculador_param: randomized and directed checks of recirculador_param against a behavioural model.
// Build with RECIRC_LANE_CHECK_EN defined to also cover lane_err.
module tb_recirculador_param;
    localparam int L  = 4;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset_L = 1'b0;
    logic           selIdle = 1'b0;
    logic [L*W-1:0] dataIn = '0;
    logic [L-1:0]   validIn = '0;
    logic           cntClr = 1'b0;
    logic [L*W-1:0] dataFwd, dataRec;
    logic [L-1:0]   validFwd, validRec;
    logic           mode;
    logic [CW-1:0]  fwdCount;
    logic           laneErr;

    int total = 0;
    int bad = 0;

    logic [L*W-1:0] eFwd, eRec;
    logic [L-1:0]   eVf, eVr;
    int             mMode, mRun, mCnt, mErr;

    recirculador_param #(.DATA_W(W), .LANES(L), .HOLD(H), .CNT_W(CW)) dut (
        .clk(clk), .reset_L(reset_L), .selector_IDLE(selIdle), .data_in(dataIn),
        .valid_in(validIn), .cnt_clr(cntClr), .data_fwd(dataFwd), .valid_fwd(validFwd),
        .data_rec(dataRec), .valid_rec(validRec), .mode(mode), .fwd_count(fwdCount)
`ifdef RECIRC_LANE_CHECK_EN
        , .lane_err(laneErr)
`endif
    );
`ifndef RECIRC_LANE_CHECK_EN
    assign laneErr = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        eFwd = '0; eRec = '0; eVf = '0; eVr = '0;
        mMode = 0; mRun = 0; mCnt = 0; mErr = 0;
    endtask

    task automatic checkAll();
        check("mode", 64'(mode), 64'(mMode));
        check("data_fwd", 64'(dataFwd), 64'(eFwd));
        check("valid_fwd", 64'(validFwd), 64'(eVf));
        check("data_rec", 64'(dataRec), 64'(eRec));
        check("valid_rec", 64'(validRec), 64'(eVr));
        check("fwd_count", 64'(fwdCount), 64'(mCnt));
`ifdef RECIRC_LANE_CHECK_EN
        check("lane_err", 64'(laneErr), 64'(mErr));
`endif
    endtask

    // one clock: drive inputs, advance the model from its pre-edge state, compare
    task automatic step(input logic s, input logic [L-1:0] v, input logic [L*W-1:0] d, input logic c);
        logic [L*W-1:0] m;
        selIdle = s; validIn = v; dataIn = d; cntClr = c;
        @(posedge clk);
        for (int i = 0; i < L; i++) m[i*W +: W] = v[i] ? d[i*W +: W] : '0;
        eFwd = mMode != 0 ? m : '0;
        eVf  = mMode != 0 ? v : '0;
        eRec = mMode != 0 ? '0 : m;
        eVr  = mMode != 0 ? '0 : v;
        if (c) mCnt = 0;
        else if (mMode != 0) mCnt = (mCnt + $countones(v) > MAXC) ? MAXC : mCnt + $countones(v);
        mErr = ((v != '0 && v != '1) || (mErr != 0 && !c)) ? 1 : 0;
        if (int'(s) != mMode) begin
            mRun++;
            if (mRun == H) begin mMode = int'(s); mRun = 0; end
        end else begin
            mRun = 0;
        end
        #1;
        checkAll();
    endtask

    initial begin
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        reset_L = 1'b1;

        // RECIRC routing, then selector change takes HOLD edges
        step(0, 4'hF, 32'hCCDDEEFF, 0);
        check("t1 rec data", 64'(dataRec), 64'hCCDDEEFF);
        step(1, 4'hF, 32'h11223344, 0);
        check("t1 mode k", 64'(mode), 64'd0);
        step(1, 4'hF, 32'h55667788, 0);
        check("t1 mode k+1", 64'(mode), 64'd1);
        check("t1 word k+1 rec", 64'(dataRec), 64'h55667788);
        step(1, 4'hF, 32'h8899AABB, 0);
        check("t1 word k+2 fwd", 64'(dataFwd), 64'h8899AABB);

        // glitch back to RECIRC, then return; one-cycle pulse must not switch
        step(0, 4'hF, 32'h01020304, 1);
        step(0, 4'hF, 32'h05060708, 0);
        check("t2 back recirc", 64'(mode), 64'd0);
        step(1, 4'hF, 32'h0A0B0C0D, 0);
        step(0, 4'hF, 32'h0E0F1011, 0);
        check("t2 glitch mode", 64'(mode), 64'd0);
        check("t2 glitch rec", 64'(dataRec), 64'h0E0F1011);

        // partial valid in FORWARD
        step(1, 4'h0, 32'h0, 0);
        step(1, 4'h0, 32'h0, 1);
        check("t3 mode", 64'(mode), 64'd1);
        step(1, 4'b0100, 32'h5A775A5A, 0);
        check("t3 lane2", 64'(dataFwd), 64'h00770000);
        step(1, 4'b0100, 32'hA577A5A5, 0);
        check("t3 count", 64'(fwdCount), 64'd2);

        // saturation at 15, clear beats increment
        step(1, 4'h0, 32'h0, 1);
        step(1, 4'hF, 32'h12345678, 0); check("t4 c1", 64'(fwdCount), 64'd4);
        step(1, 4'hF, 32'h12345678, 0); check("t4 c2", 64'(fwdCount), 64'd8);
        step(1, 4'hF, 32'h12345678, 0); check("t4 c3", 64'(fwdCount), 64'd12);
        step(1, 4'hF, 32'h12345678, 0); check("t4 c4", 64'(fwdCount), 64'd15);
        step(1, 4'hF, 32'h12345678, 0); check("t4 c5", 64'(fwdCount), 64'd15);
        step(1, 4'hF, 32'h12345678, 1); check("t4 clr", 64'(fwdCount), 64'd0);

        // lane alignment flag: set wins over clear, clear with aligned valid drops it
        step(1, 4'b1011, 32'hDEADBEEF, 0);
        step(1, 4'hF, 32'hDEADBEEF, 0);
        step(1, 4'b1011, 32'hDEADBEEF, 1);
        step(1, 4'hF, 32'hDEADBEEF, 1);
`ifdef RECIRC_LANE_CHECK_EN
        check("t6 err cleared", 64'(laneErr), 64'd0);
`endif

        // asynchronous reset between edges with count 9
        step(1, 4'b0111, 32'h01010101, 0);
        step(1, 4'b0111, 32'h02020202, 0);
        step(1, 4'b0111, 32'h03030303, 0);
        check("t5 count9", 64'(fwdCount), 64'd9);
        #2 reset_L = 1'b0;
        #1;
        resetModel();
        checkAll();
        check("t5 fwd valid", 64'(validFwd), 64'd0);
        @(negedge clk);
        reset_L = 1'b1;

        // random traffic with a sticky selector and occasional clears
        for (int n = 0; n < 400; n++) begin
            logic s;
            s = ($urandom_range(3) == 0) ? ~selIdle : selIdle;
            step(s, 4'($urandom), $urandom, $urandom_range(15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/recirculador_param.md
Name: recirculador_param

Overview:
- Parametrised successor of the 4-lane recirculator, sitting between the lane-striping stage and the PHY transmit path.
- Routes LANES parallel data lanes to one of two registered output groups:
  - forward group, toward the PHY, when the link is out of IDLE;
  - recirculate group, back to the source, while IDLE.
- Adds a debounced mode FSM, a saturating forwarded-word counter and optional lane-alignment checking.

Parameters:
DATA_W, 8, bits per lane word
LANES, 4, number of parallel lanes (>=1)
HOLD, 2, consecutive cycles selector_IDLE must disagree with current mode before mode changes (>=1)
CNT_W, 16, width of forwarded-word counter

Ports:
clk  input  1  single clock, all logic on rising edge
reset_L  input  1  asynchronous, active-low reset
selector_IDLE  input  1  1 = request FORWARD mode, 0 = request RECIRC mode
data_in  input  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W]
valid_in  input  LANES  per-lane valid
cnt_clr  input  1  synchronous clear of fwd_count
data_fwd  output  LANES*DATA_W  forward-path data, registered
valid_fwd  output  LANES  forward-path valid, registered
data_rec  output  LANES*DATA_W  recirculate-path data, registered
valid_rec  output  LANES  recirculate-path valid, registered
mode  output  1  current FSM state: 0 = RECIRC, 1 = FORWARD
fwd_count  output  CNT_W  saturating count of valid lane-words sent forward

Behaviour:
- Reset (reset_L = 0, asynchronous, also mid-operation): all outputs 0; mode = RECIRC; debounce counter = 0; held from assertion until the first rising edge after release.
- FSM has 2 states, RECIRC and FORWARD. At each edge:
  - if selector_IDLE != mode:
    - debounce count == HOLD-1 → mode <= selector_IDLE, count <= 0;
    - otherwise count <= count+1;
  - if selector_IDLE == mode: count <= 0.
  - HOLD=1: mode follows selector_IDLE with 1 cycle of delay.
- Routing, per lane i, at each edge, using the mode value before the edge:
  - RECIRC: data_rec[i] <= data_in[i], valid_rec[i] <= valid_in[i]; valid_fwd[i] <= 0, data_fwd[i] <= 0.
  - FORWARD: mirror image.
  - The word sampled on the edge where mode flips still goes to the old path. No word is ever duplicated or dropped.
- Output latency: 1 cycle, input at edge k is visible after edge k.
- Lanes with valid_in[i]=0 drive data 0 on both groups, never pass-through X.
- fwd_count at each edge:
  - adds popcount(valid_in) when the routing mode is FORWARD;
  - saturates at 2^CNT_W-1, no wrap;
  - cnt_clr=1 forces 0 on that edge, and clear wins over a simultaneous increment.
- Per-lane data paths are independent: lanes may be valid in any combination.

Optional Feature:
- Macro: RECIRC_LANE_CHECK_EN.
- When defined:
  - adds output lane_err (1 bit, reset 0).
  - lane_err is set at any edge where valid_in is neither all-ones nor all-zeros, i.e. lanes misaligned.
  - lane_err is sticky until cnt_clr=1 or reset.
  - A misalignment and cnt_clr on the same edge leave lane_err = 1 (set wins).
- When undefined: no lane_err port, no checking logic; all other behaviour is identical.

Test Plan:
1. Reset then HOLD=2, LANES=4. Sequence:
   - valid_in=4'hF, data FF/EE/DD/CC, selector_IDLE=0 → data_rec=CC_DD_EE_FF, valid_rec=F, valid_fwd=0, fwd_count=0.
   - selector_IDLE=1 at edge k → mode=1 after edge k+1.
   - Words sampled at edges k and k+1 appear on the rec group; the word at edge k+2 (BB/AA/99/88) appears on the fwd group.
2. Glitch: selector_IDLE pulses 1 for one cycle with HOLD=2 → mode stays 0, all words stay on the rec group.
3. Partial valid: in FORWARD, valid_in=4'b0100, data lane2=77, others X → data_fwd lane2=77, other lanes 00, fwd_count +1 per cycle.
4. Saturation: CNT_W=4, FORWARD, valid_in=F for 5 cycles → fwd_count 4, 8, 12, 15, 15.
   - Then cnt_clr=1 together with valid_in=F → 0.
5. Reset mid-stream: reset_L=0 between edges while in FORWARD with count=9 → all outputs and mode go to 0 immediately, without waiting for a clock edge.
6. RECIRC_LANE_CHECK_EN defined: valid_in=4'b1011 for one cycle → lane_err=1 and stays 1.
   - cnt_clr=1 with valid_in=F → lane_err=0.
